// File: rtl/ex_stage.sv
// Execute stage: ALU, branch target, write-register select and a
// 32-step shift-add multiplier feeding the EX/MEM pipeline register.
//
// Ports:
//   clk, startin          clock and synchronous active-high reset
//   EX_valid, EX_flush    slot valid and synchronous kill of the EX op
//   EX_wb, EX_m           WB/MEM control bits, passed through
//   EX_reg_dst            1 selects rd, 0 selects rt
//   EX_alu_op, EX_alu_src ALU class and operand-B select
//   EX_pc_plus_4          PC+4 of the instruction
//   EX_reg_data1/2        operand A, register operand B / store data
//   EX_sign_ext_imm       immediate, [5:0] doubles as funct
//   EX_instr_20_16/15_11  rt and rd fields
//   ex_stall              hold request to ID/EX and upstream stages
//   MEM_*                 registered EX/MEM outputs
module ex_stage (
    input  logic        clk,
    input  logic        startin,
    input  logic        EX_valid,
    input  logic        EX_flush,
    input  logic [1:0]  EX_wb,
    input  logic [2:0]  EX_m,
    input  logic        EX_reg_dst,
    input  logic [1:0]  EX_alu_op,
    input  logic        EX_alu_src,
    input  logic [31:0] EX_pc_plus_4,
    input  logic [31:0] EX_reg_data1,
    input  logic [31:0] EX_reg_data2,
    input  logic [31:0] EX_sign_ext_imm,
    input  logic [4:0]  EX_instr_20_16,
    input  logic [4:0]  EX_instr_15_11,
    output logic        ex_stall,
    output logic        MEM_valid,
    output logic [1:0]  MEM_wb,
    output logic [2:0]  MEM_m,
    output logic [31:0] MEM_branch_target,
    output logic        MEM_zero,
    output logic [31:0] MEM_alu_result,
    output logic [31:0] MEM_reg_data2,
    output logic [4:0]  MEM_write_reg
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;
    localparam logic [5:0] F_MUL = 6'h18;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;

    logic        mem_valid_q, mem_valid_d;
    logic [1:0]  mem_wb_q, mem_wb_d;
    logic [2:0]  mem_m_q, mem_m_d;
    logic [31:0] mem_bt_q, mem_bt_d;
    logic        mem_zero_q, mem_zero_d;
    logic [31:0] mem_res_q, mem_res_d;
    logic [31:0] mem_rd2_q, mem_rd2_d;
    logic [4:0]  mem_wr_q, mem_wr_d;

    logic [5:0]  funct;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic [31:0] res;
    logic        is_mul;
    logic        accept;
    logic        stall;
    logic        bubble;

    // Operand selection and ALU decode
    always_comb begin
        funct   = EX_sign_ext_imm[5:0];
        op_a    = EX_reg_data1;
        op_b    = EX_alu_src ? EX_sign_ext_imm : EX_reg_data2;
        is_mul  = (EX_alu_op == 2'b10) && (funct == F_MUL);
        alu_res = 32'h0;
        unique case (EX_alu_op)
            2'b00: alu_res = op_a + op_b;
            2'b01: alu_res = op_a - op_b;
            2'b11: alu_res = op_a | op_b;
            2'b10: begin
                case (funct)
                    F_ADD:   alu_res = op_a + op_b;
                    F_SUB:   alu_res = op_a - op_b;
                    F_AND:   alu_res = op_a & op_b;
                    F_OR:    alu_res = op_a | op_b;
                    F_SLT:   alu_res = {31'h0,
                                 $signed(op_a) < $signed(op_b)};
                    default: alu_res = 32'h0;
                endcase
            end
            default: alu_res = 32'h0;
        endcase
    end

    // Multiplier FSM: one shift-add step per MUL cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        stall    = 1'b0;
        accept   = (state_q == S_IDLE) && EX_valid &&
                   is_mul && !EX_flush;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_MUL;
                    cnt_d    = 5'd0;
                    acc_d    = 32'h0;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    stall    = 1'b1;
                end
            end
            S_MUL: begin
                stall = 1'b1;
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Inputs still show the held MUL; do not restart it
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (EX_flush) begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
            stall   = 1'b0;
        end
        if (startin) begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
            stall   = 1'b0;
        end
    end

    assign ex_stall = stall;

    // EX/MEM next values; datapath fields load even in a bubble
    always_comb begin
        res         = (state_q == S_DONE) ? acc_q : alu_res;
        bubble      = stall || !EX_valid || EX_flush;
        mem_valid_d = !bubble;
        mem_wb_d    = bubble ? 2'b00 : EX_wb;
        mem_m_d     = bubble ? 3'b000 : EX_m;
        mem_bt_d    = EX_pc_plus_4 + (EX_sign_ext_imm << 2);
        mem_res_d   = res;
        mem_zero_d  = (res == 32'h0);
        mem_rd2_d   = EX_reg_data2;
        mem_wr_d    = EX_reg_dst ? EX_instr_15_11 : EX_instr_20_16;
    end

    always_ff @(posedge clk) begin
        if (startin) begin
            state_q     <= S_IDLE;
            cnt_q       <= 5'd0;
            acc_q       <= 32'h0;
            mcand_q     <= 32'h0;
            mplier_q    <= 32'h0;
            mem_valid_q <= 1'b0;
            mem_wb_q    <= 2'b00;
            mem_m_q     <= 3'b000;
            mem_bt_q    <= 32'h0;
            mem_zero_q  <= 1'b0;
            mem_res_q   <= 32'h0;
            mem_rd2_q   <= 32'h0;
            mem_wr_q    <= 5'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            mem_valid_q <= mem_valid_d;
            mem_wb_q    <= mem_wb_d;
            mem_m_q     <= mem_m_d;
            mem_bt_q    <= mem_bt_d;
            mem_zero_q  <= mem_zero_d;
            mem_res_q   <= mem_res_d;
            mem_rd2_q   <= mem_rd2_d;
            mem_wr_q    <= mem_wr_d;
        end
    end

    assign MEM_valid         = mem_valid_q;
    assign MEM_wb            = mem_wb_q;
    assign MEM_m             = mem_m_q;
    assign MEM_branch_target = mem_bt_q;
    assign MEM_zero          = mem_zero_q;
    assign MEM_alu_result    = mem_res_q;
    assign MEM_reg_data2     = mem_rd2_q;
    assign MEM_write_reg     = mem_wr_q;

endmodule
